// File: rtl/line_burst_adaptor_if.sv
// Line-side (L2 pmem) and burst-side (memory) signals of the line/burst adaptor.
// master: L2 cache plus burst memory environment; slave: the adaptor itself.
interface line_burst_adaptor_if #(
  parameter int unsigned LineW  = 256,
  parameter int unsigned BurstW = 64,
  parameter int unsigned AddrW  = 32
);
  logic [AddrW-1:0]  line_address;
  logic [LineW-1:0]  line_wdata;
  logic [LineW-1:0]  line_rdata;
  logic              line_read;
  logic              line_write;
  logic              line_resp;
  logic [AddrW-1:0]  burst_address;
  logic [BurstW-1:0] burst_wdata;
  logic [BurstW-1:0] burst_rdata;
  logic              burst_read;
  logic              burst_write;
  logic              burst_resp;

  modport master (
    output line_address, line_wdata, line_read, line_write, burst_rdata, burst_resp,
    input  line_rdata, line_resp, burst_address, burst_wdata, burst_read, burst_write
  );

  modport slave (
    input  line_address, line_wdata, line_read, line_write, burst_rdata, burst_resp,
    output line_rdata, line_resp, burst_address, burst_wdata, burst_read, burst_write
  );
endinterface

// File: rtl/line_burst_adaptor.sv
// Splits 256-bit L2 line reads/writes into 4-beat 64-bit bursts, one transaction at a time.
// Optional build macro ADAPTOR_STATS_EN adds completed read/write line counters.
module line_burst_adaptor #(
  parameter int unsigned LineW  = 256,
  parameter int unsigned BurstW = 64,
  parameter int unsigned AddrW  = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  line_burst_adaptor_if.slave bus
`ifdef ADAPTOR_STATS_EN
  ,
  output logic [31:0]         o_rd_lines,
  output logic [31:0]         o_wr_lines
`endif
);

  localparam int unsigned Beats = LineW / BurstW;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned OffW  = $clog2(LineW / 8);
  localparam logic [CntW-1:0] CntLast = CntW'(Beats - 1);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e            r_state;
  logic [CntW-1:0]   r_cnt;
  logic [AddrW-1:0]  r_addr;
  logic [LineW-1:0]  r_wline;
  logic [BurstW-1:0] r_wdata;
  logic [LineW-1:0]  r_rdata;
  logic              r_read;
  logic              r_write;
  logic              r_resp;
`ifdef ADAPTOR_STATS_EN
  logic [31:0]       r_rd_lines;
  logic [31:0]       r_wr_lines;
`endif

  logic [CntW-1:0]   w_cnt_nxt;
  logic [AddrW-1:0]  w_line_base;
  logic              w_unused_offset;

  assign w_cnt_nxt       = r_cnt + 1'b1;
  assign w_line_base     = {bus.line_address[AddrW-1:OffW], {OffW{1'b0}}};
  assign w_unused_offset = ^bus.line_address[OffW-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wline <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
`ifdef ADAPTOR_STATS_EN
      r_rd_lines <= '0;
      r_wr_lines <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          // Writeback takes priority so a dirty victim leaves before its refill arrives.
          if (bus.line_write) begin
            r_addr  <= w_line_base;
            r_wline <= bus.line_wdata;
            r_wdata <= bus.line_wdata[BurstW-1:0];
            r_cnt   <= '0;
            r_write <= 1'b1;
            r_state <= StWr;
          end else if (bus.line_read) begin
            r_addr  <= w_line_base;
            r_cnt   <= '0;
            r_read  <= 1'b1;
            r_state <= StRd;
          end
        end
        StRd: begin
          if (bus.burst_resp) begin
            r_rdata[BurstW*r_cnt +: BurstW] <= bus.burst_rdata;
            r_cnt <= w_cnt_nxt;
            if (r_cnt == CntLast) begin
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= StDone;
`ifdef ADAPTOR_STATS_EN
              r_rd_lines <= r_rd_lines + 32'd1;
`endif
            end
          end
        end
        StWr: begin
          if (bus.burst_resp) begin
            r_cnt <= w_cnt_nxt;
            if (r_cnt == CntLast) begin
              r_write <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= StDone;
`ifdef ADAPTOR_STATS_EN
              r_wr_lines <= r_wr_lines + 32'd1;
`endif
            end else begin
              r_wdata <= r_wline[BurstW*w_cnt_nxt +: BurstW];
            end
          end
        end
        StDone: begin
          r_resp  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.line_rdata    = r_rdata;
  assign bus.line_resp     = r_resp;
  assign bus.burst_address = r_addr;
  assign bus.burst_wdata   = r_wdata;
  assign bus.burst_read    = r_read;
  assign bus.burst_write   = r_write;

`ifdef ADAPTOR_STATS_EN
  assign o_rd_lines = r_rd_lines;
  assign o_wr_lines = r_wr_lines;
`endif

endmodule
